// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and data (D).
// D wins ties until its streak hits MAX_D_STREAK; a watchdog ends hung accesses.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE, GNT_I, GNT_D, RESP
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_streak;
  logic [CNT_W-1:0] r_cnt;
  logic            r_owner;
  logic            r_mreq;
  logic            r_mwe;
  logic [31:0]     r_maddr;
  logic [31:0]     r_mwdata;
  logic [3:0]      r_mbe;
  logic            r_idone;
  logic            r_ddone;
  logic [31:0]     r_irdata;
  logic [31:0]     r_drdata;
  logic            r_ierr;
  logic            r_derr;

  logic w_force_i;
  logic w_tmo;

  assign w_force_i = (r_streak == SW'(MAX_D_STREAK));
  assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_mreq   <= 1'b0;
      r_mwe    <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_mbe    <= '0;
      r_idone  <= 1'b0;
      r_ddone  <= 1'b0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_ierr   <= 1'b0;
      r_derr   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (d_req && !(i_req && w_force_i)) begin
            r_state  <= GNT_D;
            r_owner  <= 1'b1;
            r_mreq   <= 1'b1;
            r_maddr  <= d_addr;
            r_mwe    <= d_we;
            r_mwdata <= d_wdata;
            r_mbe    <= d_we ? d_byteen : 4'b0000;
            r_streak <= i_req ? r_streak + SW'(1) : '0;
          end else if (i_req) begin
            r_state  <= GNT_I;
            r_owner  <= 1'b0;
            r_mreq   <= 1'b1;
            r_maddr  <= i_addr;
            r_mwe    <= 1'b0;
            r_mwdata <= '0;
            r_mbe    <= 4'b0000;
            r_streak <= '0;
          end
        end
        GNT_I, GNT_D: begin
          // A ready on the last watchdog cycle still counts as success
          if (mem_ready || w_tmo) begin
            r_state <= RESP;
            r_mreq  <= 1'b0;
            r_cnt   <= '0;
            if (r_owner) begin
              r_ddone  <= 1'b1;
              r_derr   <= !mem_ready;
              r_drdata <= (mem_ready && !r_mwe) ? mem_rdata : '0;
            end else begin
              r_idone  <= 1'b1;
              r_ierr   <= !mem_ready;
              r_irdata <= mem_ready ? mem_rdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_idone <= 1'b0;
          r_ddone <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_done     = r_idone;
  assign i_rdata    = r_irdata;
  assign i_err      = r_ierr;
  assign d_done     = r_ddone;
  assign d_rdata    = r_drdata;
  assign d_err      = r_derr;
  assign mem_req    = r_mreq;
  assign mem_we     = r_mwe;
  assign mem_addr   = r_maddr;
  assign mem_wdata  = r_mwdata;
  assign mem_byteen = r_mbe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grant and response queues
// filled by the stimulus, drained by an independent monitor.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  len;
  } gnt_t;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];

  int          errors;
  int          checks;
  int          tmo;
  int          mem_lat;
  bit          stray;
  bit          finish_req;
  logic [31:0] mem_data;

  mem_port_arbiter #(
    .MAX_D_STREAK(4),
    .TIMEOUT(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_done(i_done),
    .i_rdata(i_rdata),
    .i_err(i_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_byteen(d_byteen),
    .d_done(d_done),
    .d_rdata(d_rdata),
    .d_err(d_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Memory model: ready after mem_lat cycles of mem_req (-1 = never)
  initial begin : responder
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ready = (mem_lat >= 0) && (wcnt == mem_lat);
        mem_rdata = mem_ready ? mem_data : 32'h0;
        wcnt++;
      end else begin
        wcnt = 0;
        mem_ready = stray;
        mem_rdata = stray ? 32'hBAD0BAD0 : 32'h0;
      end
    end
  end

  initial begin : monitor
    gnt_t        g;
    rsp_t        r;
    logic        prev_req;
    int          cur_len;
    int          cur_exp;
    logic [31:0] ard;
    logic        aerr;
    errors = 0;
    checks = 0;
    prev_req = 1'b0;
    cur_len = 0;
    cur_exp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_byteen,
             i_done, d_done, i_rdata, d_rdata, i_err, d_err} != '0) begin
          errors++;
          $display("FAIL reset_outputs: mem_req=%0b d_done=%0b i_done=%0b mem_addr=%h required all zero",
                   mem_req, d_done, i_done, mem_addr);
        end
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          checks++;
          if (gq.size() == 0) begin
            errors++;
            $display("FAIL grant: unexpected grant addr=%h", mem_addr);
            cur_exp = 0;
          end else begin
            g = gq.pop_front();
            if (mem_addr !== g.addr || mem_we !== g.we ||
                mem_wdata !== g.wdata || mem_byteen !== g.be) begin
              errors++;
              $display("FAIL grant: got addr=%h we=%b wdata=%h be=%b required addr=%h we=%b wdata=%h be=%b",
                       mem_addr, mem_we, mem_wdata, mem_byteen,
                       g.addr, g.we, g.wdata, g.be);
            end
            cur_exp = int'(g.len);
          end
          cur_len = 1;
        end else if (mem_req) begin
          cur_len++;
        end else if (prev_req && cur_exp != 0) begin
          checks++;
          if (cur_len != cur_exp) begin
            errors++;
            $display("FAIL req_len: mem_req high %0d cycles required %0d",
                     cur_len, cur_exp);
          end
        end
        prev_req = mem_req;
        if (i_done && d_done) begin
          checks++;
          errors++;
          $display("FAIL both_done: i_done and d_done together");
        end else if (i_done || d_done) begin
          checks++;
          ard  = d_done ? d_rdata : i_rdata;
          aerr = d_done ? d_err : i_err;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL done: unexpected done port=%0b", d_done);
          end else begin
            r = rq.pop_front();
            if (d_done !== r.port || ard !== r.rdata || aerr !== r.err) begin
              errors++;
              $display("FAIL done: got port=%0b rdata=%h err=%b required port=%0b rdata=%h err=%b",
                       d_done, ard, aerr, r.port, r.rdata, r.err);
            end
          end
        end
      end
      if (finish_req) begin
        checks++;
        if (gq.size() != 0 || rq.size() != 0 || tmo != 0) begin
          errors++;
          $display("FAIL drain: grants left=%0d responses left=%0d waits expired=%0d required 0/0/0",
                   gq.size(), rq.size(), tmo);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  task automatic wait_done(input bit is_d, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (is_d ? d_done : i_done) break;
      n++;
    end
    if (n >= budget) begin
      $display("FAIL wait_done: no done on port %0b within %0d cycles",
               is_d, budget);
      tmo++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input int lat,
                       input logic [31:0] dat, input logic [7:0] len);
    mem_lat  = lat;
    mem_data = dat;
    gq.push_back('{a, 1'b0, 32'h0, 4'b0000, len});
    rq.push_back('{1'b0, dat, 1'b0});
    i_addr = a;
    i_req  = 1'b1;
    wait_done(1'b0, 40);
    i_req  = 1'b0;
  endtask

  task automatic dread(input logic [31:0] a, input int lat,
                       input logic [31:0] dat, input logic [7:0] len,
                       input logic [31:0] erd, input logic eerr);
    mem_lat  = lat;
    mem_data = dat;
    gq.push_back('{a, 1'b0, 32'h0, 4'b0000, len});
    rq.push_back('{1'b1, erd, eerr});
    d_addr = a;
    d_we   = 1'b0;
    d_req  = 1'b1;
    wait_done(1'b1, 40);
    d_req  = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    int cyc;
    tmo = 0;
    finish_req = 1'b0;
    stray = 1'b0;
    mem_lat = 0;
    mem_data = '0;
    reset = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_byteen = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    fetch(32'h0000_3000, 2, 32'h2401_0001, 8'd3);

    mem_lat  = 0;
    mem_data = 32'h1234_5678;
    gq.push_back('{32'h4, 1'b1, 32'hDEAD_BEEF, 4'b0011, 8'd1});
    rq.push_back('{1'b1, 32'h0, 1'b0});
    d_addr   = 32'h4;
    d_we     = 1'b1;
    d_wdata  = 32'hDEAD_BEEF;
    d_byteen = 4'b0011;
    d_req    = 1'b1;
    wait_done(1'b1, 40);
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_wdata  = '0;
    d_byteen = '0;
    repeat (2) @(posedge clk);
    #1;

    mem_lat  = 0;
    mem_data = 32'h1111_2222;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        gq.push_back('{32'h1000, 1'b0, 32'h0, 4'b0000, 8'd1});
        rq.push_back('{1'b0, 32'h1111_2222, 1'b0});
      end else begin
        gq.push_back('{32'h2000, 1'b0, 32'h0, 4'b0000, 8'd1});
        rq.push_back('{1'b1, 32'h1111_2222, 1'b0});
      end
    end
    i_addr   = 32'h1000;
    d_addr   = 32'h2000;
    d_byteen = 4'b1111;
    i_req    = 1'b1;
    d_req    = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      if (i_done || d_done) n++;
      cyc++;
    end
    if (n < 10) begin
      $display("FAIL priority_wait: %0d dones required 10", n);
      tmo++;
    end
    @(posedge clk);
    #1;
    i_req    = 1'b0;
    d_req    = 1'b0;
    d_byteen = '0;
    repeat (2) @(posedge clk);
    #1;

    dread(32'h40, -1, 32'hCAFE_F00D, 8'd16, 32'h0, 1'b1);
    fetch(32'h0000_3004, 1, 32'h8C22_0000, 8'd2);

    dread(32'h80, 15, 32'h0BAD_CAFE, 8'd16, 32'h0BAD_CAFE, 1'b0);

    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fetch(32'h0000_3008, 0, 32'h0000_0013, 8'd1);

    mem_lat = -1;
    gq.push_back('{32'h100, 1'b0, 32'h0, 4'b0000, 8'd0});
    d_addr = 32'h100;
    d_we   = 1'b0;
    d_req  = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #4 d_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dread(32'h104, 0, 32'h55AA_55AA, 8'd1, 32'h55AA_55AA, 1'b0);

    repeat (3) @(posedge clk);
    #1 finish_req = 1'b1;
    repeat (4) @(posedge clk);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the CPU instruction-fetch requester (I, read-only) and the data requester (D, read/write with byte enables).
- Serialises the accesses with a four-state FSM.
- Data has priority, bounded by an anti-starvation streak counter.
- A watchdog terminates hung memory transactions with an error response.
- Sits between the pipeline's fetch/memory stages and the memory/bridge; the pipeline stalls while its request is pending.

Parameters:
- MAX_D_STREAK, 4: max consecutive D grants while I is waiting before I is forced through (≥1).
- TIMEOUT, 16: cycles in a grant state without mem_ready before an error response (≥2).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req  in  1  fetch request; held with i_addr stable until i_done
- i_addr  in  32  fetch word address
- i_done  out  1  one-cycle response pulse to I
- i_rdata  out  32  fetch data, valid while i_done=1
- i_err  out  1  timeout flag, valid while i_done=1
- d_req  in  1  data request; held with d_we, d_addr, d_wdata, d_byteen stable until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_byteen  in  4  byte enables for writes
- d_done  out  1  one-cycle response pulse to D
- d_rdata  out  32  read data, valid while d_done=1 (0 for writes)
- d_err  out  1  timeout flag, valid while d_done=1
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write strobe qualifier
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered write data
- mem_byteen  out  4  registered byte enables (4'b0000 for reads)
- mem_rdata  in  32  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completion, single-cycle pulse

Behaviour:
- States: IDLE, GNT_I, GNT_D, RESP.
- Reset values: state IDLE; all outputs 0; streak counter 0; timeout counter 0; owner flag 0.
- Reset mid-transaction: the transaction is abandoned and no done pulse is issued.

IDLE:
- Neither request: stay in IDLE.
- Only i_req: go to GNT_I.
- Only d_req: go to GNT_D.
- Both requests:
  - streak == MAX_D_STREAK: go to GNT_I.
  - otherwise: go to GNT_D and increment streak.
- Any I grant clears streak to 0.
- A D grant while i_req=0 also clears streak to 0.
- On the grant edge, requester fields are latched into mem_addr/mem_we/mem_wdata/mem_byteen. For I: we=0, byteen=0. For D reads: byteen forced to 0.
- The owner flag is recorded on the same edge; mem_req goes 1 on the same edge.

GNT_I / GNT_D:
- mem_req=1 and latched fields held constant.
- Timeout counter increments each cycle without mem_ready.
- mem_ready=1:
  - Capture mem_rdata into the owner's rdata register; write data returns 0.
  - err=0; go to RESP; mem_req→0.
- Counter reaches TIMEOUT-1 and mem_ready=0:
  - rdata=0, err=1; go to RESP; mem_req→0.
- Same cycle mem_ready=1 and timeout: success wins.
- Counter is cleared on entering RESP.

RESP:
- Exactly one cycle; owner's done=1; then return to IDLE.
- No grant is made in RESP. This guarantees the just-served requester, which still holds req this cycle, is not re-granted.
- Minimum service time: request high in IDLE at edge k, mem_ready at cycle k+1 → done in cycle k+2, IDLE at k+3.

Other rules:
- mem_ready while in IDLE or RESP is ignored and has no side effects.
- Requests arriving in grant/RESP states wait; no queueing beyond the held req level.
- rdata/err registers hold their last values; they are only meaningful while done=1.
- done outputs never assert in the same cycle for both ports.

Test Plan:
- Single fetch: i_req=1, i_addr=0x3000, mem_ready 2 cycles after mem_req, mem_rdata=0x24010001 → mem_addr=0x3000, mem_we=0, i_done pulse one cycle after mem_ready, i_rdata=0x24010001, i_err=0.
- Data write: d_req=1, d_we=1, d_addr=0x0004, d_wdata=0xDEADBEEF, d_byteen=4'b0011, immediate mem_ready → mem_byteen=4'b0011, mem_wdata=0xDEADBEEF, d_done with d_rdata=0, d_err=0; no i_done.
- Priority/starvation with MAX_D_STREAK=4: i_req and d_req held continuously, each requester re-raising req one cycle after its done → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout with TIMEOUT=16: d_req read, mem_ready never asserted → mem_req high exactly 16 cycles, then d_done=1, d_err=1, d_rdata=0; following fetch completes normally with i_err=0.
- Edge events: mem_ready on the final timeout cycle → err=0 with data captured. Stray mem_ready in IDLE → no done pulse. reset asserted asynchronously while in GNT_D → mem_req drops immediately, no d_done, FSM in IDLE.
